seg_serial_driver: RTL and testbench
====================================

Name: seg_serial_driver

Overview:
- Serializer feeding the board's 7-segment shift-register chain (SEGLED_CLK / SEGLED_DO / SEGLED_PEN pins of mips_top).
- Accepts a parallel segment image from the display-formatting logic and shifts it out MSB-first on a divided serial clock.
- Drives the latch/enable line at the end of each frame so the display updates atomically.
- Sits directly between the top-level display mux and the SEGLED output pins.

Parameters:
- DATA_W, 64: bits per frame (8 digits × 8 segments); legal range ≥ 2.
- HALF_PERIOD, 4: clk cycles per s_clk half-period; legal range ≥ 1.
- REFRESH_GAP, 1024: idle clk cycles between auto-refresh frames; used only with SEG_AUTO_REFRESH_EN.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  DATA_W  segment image; sampled only on the accepting edge.
- start  input  1  frame request; level-sampled.
- busy  output  1  high from the accepting edge until frame completion.
- done  output  1  one-cycle pulse at frame completion.
- s_clk  output  1  serial shift clock to SEGLED_CLK.
- s_dat  output  1  serial data to SEGLED_DO.
- s_pen  output  1  latch/enable to SEGLED_PEN; high = display shows latched data.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, s_clk=0, s_dat=0, s_pen=1, bit counter=0, divider=0, shift register=0.
- Reset mid-frame abandons the frame; no done pulse is generated.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - start=1 on a rising edge → capture data into the shift register, busy←1, s_pen←0, s_clk←0, s_dat←data[DATA_W-1], go to SHIFT_LO.
  - start=0 → remain in IDLE.
- SHIFT_LO:
  - s_clk=0; s_dat holds the current MSB.
  - After HALF_PERIOD cycles → SHIFT_HI, s_clk←1. The external register samples on this rising s_clk.
- SHIFT_HI:
  - s_clk=1.
  - After HALF_PERIOD cycles: shift register shifts left by 1, bit counter increments, s_clk←0.
  - If bit counter reaches DATA_W → LATCH; otherwise → SHIFT_LO with s_dat←new MSB.
- LATCH:
  - s_clk=0, s_dat=0, s_pen=0 for HALF_PERIOD cycles.
  - Then on one edge: s_pen←1, busy←0, done←1 (for one cycle), go to IDLE.
- Latency: busy is high for exactly (2·DATA_W+1)·HALF_PERIOD cycles. done is asserted in the cycle after busy's last high cycle.
- Divider:
  - Counts 0..HALF_PERIOD-1, resets on every state change.
  - Width: $clog2(HALF_PERIOD), minimum 1.
- Bit counter width: $clog2(DATA_W+1).
- Handshake:
  - start while busy=1 is ignored (not queued).
  - start on the same edge that done is asserted is not accepted; acceptance is possible from the following edge.
  - data changes while busy do not affect the frame in flight.
- Exactly DATA_W rising edges of s_clk per frame. s_clk never glitches; s_dat changes only while s_clk=0.

Optional Feature:
- Macro: SEG_AUTO_REFRESH_EN.
- Defined:
  - An idle gap counter runs while in IDLE.
  - When the counter reaches REFRESH_GAP with start=0, a frame starts automatically using the current data, with the same timing as a start-initiated frame.
  - An explicit start takes priority and clears the gap counter; reset clears the counter.
  - done pulses for auto frames too.
- Undefined:
  - Frames start only on start; there is no gap counter logic and REFRESH_GAP is unused.

Decomposition:
- Shared display package holds:
  - state encoding typedef (IDLE/SHIFT_LO/SHIFT_HI/LATCH, 2-bit);
  - default constants SEG_DATA_W=64 and SEG_HALF_PERIOD=4.
- One natural sub-module: seg_clk_div, a half-period tick generator with a sync clear, outputting a one-cycle tick every HALF_PERIOD cycles.
- The FSM and shift register stay in the parent.

Test Plan:
- Reset check: rst=1 mid-SHIFT_HI → outputs immediately go to busy=0, s_clk=0, s_dat=0, s_pen=1; no done pulse follows.
- Basic frame: DATA_W=8, HALF_PERIOD=2, data=8'hA5, 1-cycle start → s_dat sampled at the 8 s_clk rising edges = 1,0,1,0,0,1,0,1; busy high 34 cycles; done single pulse; s_pen low for exactly 34 cycles.
- Busy ignore: DATA_W=8, HALF_PERIOD=2, second start with data=8'hFF at cycle 10 of a frame → still exactly 8 s_clk rising edges, serialized data is 8'hA5, one done pulse, busy not extended.
- Back-to-back: DATA_W=8, HALF_PERIOD=2, start held high continuously → frames separated by exactly 1 idle cycle; each frame emits 8 s_clk rising edges.
- HALF_PERIOD=1 corner: DATA_W=64, data=64'h8000_0000_0000_0001 → first and last bits 1, all others 0; busy 129 cycles; s_clk period 2 clk cycles.
- SEG_AUTO_REFRESH_EN defined: DATA_W=8, HALF_PERIOD=2, REFRESH_GAP=16, start=0 after reset → first frame begins after 16 idle cycles, subsequent frames every 34+16 cycles, each carrying the current data.

Source files
------------

// File: rtl/seg_serial_driver_pkg.sv
// Shared display types and defaults for the 7-segment serial driver.
// Pure declarations: no logic, no latency, no backpressure.
package seg_serial_driver_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } seg_state_e;

  localparam int SEG_DATA_W      = 64;
  localparam int SEG_HALF_PERIOD = 4;

  // Counter width that never collapses to zero bits when n is 1.
  function automatic int seg_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_clk_div.sv
// Half-period tick generator: tick_o is high on every HALF_PERIOD-th cycle since clr_i dropped.
// Latency: tick is combinational from the count register; no backpressure, clr_i wins over counting.
module seg_clk_div
  import seg_serial_driver_pkg::*;
#(
  parameter int HALF_PERIOD = SEG_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = seg_cnt_w(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/seg_serial_driver.sv
// MSB-first serializer for the SEGLED chain; frame busy for (2*DATA_W+1)*HALF_PERIOD cycles, done one cycle after.
// start is ignored while busy (no queueing); SEG_AUTO_REFRESH_EN adds an idle-gap auto-refresh.
module seg_serial_driver
  import seg_serial_driver_pkg::*;
#(
  parameter int DATA_W      = SEG_DATA_W,
  parameter int HALF_PERIOD = SEG_HALF_PERIOD,
  parameter int REFRESH_GAP = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_pen
);

  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  if (DATA_W < 2 || HALF_PERIOD < 1 || REFRESH_GAP < 1) begin : g_param_check
    $error("seg_serial_driver: illegal parameter value");
  end

  seg_state_e        state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [BW-1:0]     bcnt_q;
  logic              busy_q;
  logic              done_q;
  logic              s_clk_q;
  logic              s_dat_q;
  logic              s_pen_q;
  logic              tick;
  logic              go;

  // Divider is held clear in IDLE; every tick elsewhere causes a state change, which restarts it.
  seg_clk_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );

`ifdef SEG_AUTO_REFRESH_EN
  localparam int            GW       = $clog2(REFRESH_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(REFRESH_GAP - 1);

  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;

  always_comb begin
    gap_d = '0;
    if ((state_q == IDLE) && !start && (gap_q != GAP_LAST)) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign go = start || (gap_q == GAP_LAST);
`else
  assign go = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_clk_q <= 1'b0;
      s_dat_q <= 1'b0;
      s_pen_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            sreg_q  <= data;
            bcnt_q  <= '0;
            busy_q  <= 1'b1;
            s_pen_q <= 1'b0;
            s_clk_q <= 1'b0;
            s_dat_q <= data[DATA_W-1];
            state_q <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            s_clk_q <= 1'b1;
            state_q <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sreg_q  <= sreg_q << 1;
            bcnt_q  <= bcnt_q + BW'(1);
            s_clk_q <= 1'b0;
            if (bcnt_q == LAST_BIT) begin
              s_dat_q <= 1'b0;
              state_q <= LATCH;
            end else begin
              s_dat_q <= sreg_q[DATA_W-2];
              state_q <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (tick) begin
            s_pen_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s_clk = s_clk_q;
  assign s_dat = s_dat_q;
  assign s_pen = s_pen_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: an 8-bit/HALF_PERIOD=2 instance and a 64-bit/HALF_PERIOD=1 instance.
// Expected serial bits are queued at stimulus time and compared against bits captured on s_clk rises.
module tb_seg_serial_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  data_a;
  logic        start_a;
  logic        a_busy, a_done, a_sclk, a_sdat, a_spen;
  logic [63:0] data_b;
  logic        start_b;
  logic        b_busy, b_done, b_sclk, b_sdat, b_spen;

  seg_serial_driver #(.DATA_W(8), .HALF_PERIOD(2), .REFRESH_GAP(16)) u_a (
    .clk(clk), .rst(rst), .data(data_a), .start(start_a),
    .busy(a_busy), .done(a_done), .s_clk(a_sclk), .s_dat(a_sdat), .s_pen(a_spen)
  );

  seg_serial_driver #(.DATA_W(64), .HALF_PERIOD(1), .REFRESH_GAP(1024)) u_b (
    .clk(clk), .rst(rst), .data(data_b), .start(start_b),
    .busy(b_busy), .done(b_done), .s_clk(b_sclk), .s_dat(b_sdat), .s_pen(b_spen)
  );

  int vecs = 0;
  int miss = 0;

  bit exp_a[$];
  bit obs_a[$];
  bit exp_b[$];
  bit obs_b[$];
  int a_busy_rise[$];

  int   cyc;
  int   a_busy_cyc, a_pen_cyc, a_dones, a_rises, a_bad, a_last_busy, a_done_at;
  int   b_busy_cyc, b_dones, b_rises, b_bad, b_first_rise, b_last_rise;
  logic a_psclk, a_psdat, a_pbusy, b_psclk, b_psdat;

  task automatic clear_stats();
    cyc = 0;
    a_busy_cyc = 0; a_pen_cyc = 0; a_dones = 0; a_rises = 0; a_bad = 0;
    a_last_busy = -1; a_done_at = -1;
    b_busy_cyc = 0; b_dones = 0; b_rises = 0; b_bad = 0;
    b_first_rise = -1; b_last_rise = -1;
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    a_busy_rise.delete();
    a_psclk = a_sclk; a_psdat = a_sdat; a_pbusy = a_busy;
    b_psclk = b_sclk; b_psdat = b_sdat;
  endtask

  // Advance one cycle and record what both instances did, sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (a_sclk && !a_psclk) begin a_rises++; obs_a.push_back(a_sdat); end
    if (a_sclk && (a_sdat !== a_psdat)) a_bad++;
    if (a_busy) begin a_busy_cyc++; a_last_busy = cyc; end
    if (a_busy && !a_pbusy) a_busy_rise.push_back(cyc);
    if (!a_spen) a_pen_cyc++;
    if (a_done) begin a_dones++; a_done_at = cyc; end
    if (b_sclk && !b_psclk) begin
      b_rises++; obs_b.push_back(b_sdat);
      if (b_first_rise < 0) b_first_rise = cyc;
      b_last_rise = cyc;
    end
    if (b_sclk && (b_sdat !== b_psdat)) b_bad++;
    if (b_busy) b_busy_cyc++;
    if (b_done) b_dones++;
    a_psclk = a_sclk; a_psdat = a_sdat; a_pbusy = a_busy;
    b_psclk = b_sclk; b_psdat = b_sdat;
  endtask

  task automatic push_a(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) exp_a.push_back(v[i]);
  endtask

  task automatic push_b(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) exp_b.push_back(v[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({a_busy, a_done, a_sclk, a_sdat, a_spen} !== 5'b00001) begin
      miss++; $display("FAIL reset_a outputs got %b want 00001", {a_busy, a_done, a_sclk, a_sdat, a_spen});
    end
    vecs++;
    if ({b_busy, b_done, b_sclk, b_sdat, b_spen} !== 5'b00001) begin
      miss++; $display("FAIL reset_b outputs got %b want 00001", {b_busy, b_done, b_sclk, b_sdat, b_spen});
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    clear_stats();
    data_a = 8'hA5; start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 0;
    while (a_sclk !== 1'b1 && k < 20) begin step(); k++; end
    vecs++;
    if (a_sclk !== 1'b1) begin miss++; $display("FAIL midrst_reach_hi got s_clk=%b want 1", a_sclk); end
    #1 rst = 1'b1;
    #1;
    vecs++;
    if ({a_busy, a_done, a_sclk, a_sdat, a_spen} !== 5'b00001) begin
      miss++; $display("FAIL midrst_outputs got %b want 00001", {a_busy, a_done, a_sclk, a_sdat, a_spen});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (40) step();
    vecs++;
    if (a_dones !== 0) begin miss++; $display("FAIL midrst_no_done got %0d want 0", a_dones); end
    vecs++;
    if (a_busy_cyc !== 0) begin miss++; $display("FAIL midrst_no_busy got %0d want 0", a_busy_cyc); end
  endtask

  task automatic test_basic_frame();
    clear_stats();
    push_a(8'hA5);
    data_a = 8'hA5; start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (40) step();
    vecs++; if (a_busy_cyc !== 34) begin miss++; $display("FAIL basic_busy got %0d want 34", a_busy_cyc); end
    vecs++; if (a_pen_cyc !== 34) begin miss++; $display("FAIL basic_pen_low got %0d want 34", a_pen_cyc); end
    vecs++; if (a_dones !== 1) begin miss++; $display("FAIL basic_done_count got %0d want 1", a_dones); end
    vecs++; if (a_rises !== 8) begin miss++; $display("FAIL basic_sclk_rises got %0d want 8", a_rises); end
    vecs++;
    if (a_done_at !== a_last_busy + 1) begin
      miss++; $display("FAIL basic_done_pos got %0d want %0d", a_done_at, a_last_busy + 1);
    end
    vecs++; if (a_bad !== 0) begin miss++; $display("FAIL basic_sdat_stable got %0d want 0", a_bad); end
    while (exp_a.size() > 0) begin
      bit e = exp_a.pop_front();
      vecs++;
      if (obs_a.size() == 0) begin miss++; $display("FAIL basic_bit missing want %b", e); end
      else begin
        bit o = obs_a.pop_front();
        if (o !== e) begin miss++; $display("FAIL basic_bit got %b want %b", o, e); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    clear_stats();
    push_a(8'hA5);
    data_a = 8'hA5; start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (9) step();
    data_a = 8'hFF; start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (35) step();
    vecs++; if (a_rises !== 8) begin miss++; $display("FAIL ignore_sclk_rises got %0d want 8", a_rises); end
    vecs++; if (a_dones !== 1) begin miss++; $display("FAIL ignore_done_count got %0d want 1", a_dones); end
    vecs++; if (a_busy_cyc !== 34) begin miss++; $display("FAIL ignore_busy got %0d want 34", a_busy_cyc); end
    vecs++; if (a_bad !== 0) begin miss++; $display("FAIL ignore_sdat_stable got %0d want 0", a_bad); end
    while (exp_a.size() > 0) begin
      bit e = exp_a.pop_front();
      vecs++;
      if (obs_a.size() == 0) begin miss++; $display("FAIL ignore_bit missing want %b", e); end
      else begin
        bit o = obs_a.pop_front();
        if (o !== e) begin miss++; $display("FAIL ignore_bit got %b want %b", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    repeat (3) push_a(8'hA5);
    data_a = 8'hA5; start_a = 1'b1;
    repeat (105) step();
    start_a = 1'b0;
    repeat (10) step();
    vecs++; if (a_busy_cyc !== 102) begin miss++; $display("FAIL b2b_busy got %0d want 102", a_busy_cyc); end
    vecs++; if (a_dones !== 3) begin miss++; $display("FAIL b2b_done_count got %0d want 3", a_dones); end
    vecs++; if (a_rises !== 24) begin miss++; $display("FAIL b2b_sclk_rises got %0d want 24", a_rises); end
    vecs++;
    if (a_busy_rise.size() != 3) begin
      miss++; $display("FAIL b2b_frames got %0d want 3", a_busy_rise.size());
    end else begin
      if (a_busy_rise[1] - a_busy_rise[0] !== 35) begin
        miss++; $display("FAIL b2b_spacing1 got %0d want 35", a_busy_rise[1] - a_busy_rise[0]);
      end
      vecs++;
      if (a_busy_rise[2] - a_busy_rise[1] !== 35) begin
        miss++; $display("FAIL b2b_spacing2 got %0d want 35", a_busy_rise[2] - a_busy_rise[1]);
      end
    end
    while (exp_a.size() > 0) begin
      bit e = exp_a.pop_front();
      vecs++;
      if (obs_a.size() == 0) begin miss++; $display("FAIL b2b_bit missing want %b", e); end
      else begin
        bit o = obs_a.pop_front();
        if (o !== e) begin miss++; $display("FAIL b2b_bit got %b want %b", o, e); end
      end
    end
  endtask

  task automatic test_half_period_one();
    clear_stats();
    push_b(64'h8000_0000_0000_0001);
    data_b = 64'h8000_0000_0000_0001; start_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (135) step();
    vecs++; if (b_busy_cyc !== 129) begin miss++; $display("FAIL hp1_busy got %0d want 129", b_busy_cyc); end
    vecs++; if (b_dones !== 1) begin miss++; $display("FAIL hp1_done_count got %0d want 1", b_dones); end
    vecs++; if (b_rises !== 64) begin miss++; $display("FAIL hp1_sclk_rises got %0d want 64", b_rises); end
    vecs++;
    if (b_last_rise - b_first_rise !== 126) begin
      miss++; $display("FAIL hp1_sclk_period span got %0d want 126", b_last_rise - b_first_rise);
    end
    vecs++; if (b_bad !== 0) begin miss++; $display("FAIL hp1_sdat_stable got %0d want 0", b_bad); end
    while (exp_b.size() > 0) begin
      bit e = exp_b.pop_front();
      vecs++;
      if (obs_b.size() == 0) begin miss++; $display("FAIL hp1_bit missing want %b", e); end
      else begin
        bit o = obs_b.pop_front();
        if (o !== e) begin miss++; $display("FAIL hp1_bit got %b want %b", o, e); end
      end
    end
  endtask

`ifdef SEG_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    rst = 1'b1; start_a = 1'b0; data_a = 8'hA5;
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    push_a(8'hA5);
    push_a(8'h3C);
    repeat (20) step();
    data_a = 8'h3C;
    repeat (90) step();
    vecs++; if (a_dones !== 2) begin miss++; $display("FAIL auto_done_count got %0d want 2", a_dones); end
    vecs++; if (a_rises !== 16) begin miss++; $display("FAIL auto_sclk_rises got %0d want 16", a_rises); end
    vecs++;
    if (a_busy_rise.size() < 2) begin
      miss++; $display("FAIL auto_frames got %0d want 2", a_busy_rise.size());
    end else begin
      if (a_busy_rise[0] !== 16) begin
        miss++; $display("FAIL auto_first_start got %0d want 16", a_busy_rise[0]);
      end
      vecs++;
      if (a_busy_rise[1] - a_busy_rise[0] !== 50) begin
        miss++; $display("FAIL auto_period got %0d want 50", a_busy_rise[1] - a_busy_rise[0]);
      end
    end
    while (exp_a.size() > 0) begin
      bit e = exp_a.pop_front();
      vecs++;
      if (obs_a.size() == 0) begin miss++; $display("FAIL auto_bit missing want %b", e); end
      else begin
        bit o = obs_a.pop_front();
        if (o !== e) begin miss++; $display("FAIL auto_bit got %b want %b", o, e); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_reset_mid_frame();
    test_basic_frame();
    test_busy_ignore();
    test_back_to_back();
    test_half_period_one();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
